// File: rtl/hilo_md_sequencer_pkg.sv
// Shared multiply/divide definitions: MD_OP encodings, sequencer FSM states
// and small helpers for classifying an operation.
package hilo_md_sequencer_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_CALC = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } md_state_e;

  function automatic logic md_is_div(input md_op_e op);
    return op[1];
  endfunction

  function automatic logic md_is_signed(input md_op_e op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/hilo_md_sequencer_md_iter_step.sv
// One combinational iteration of shift-add multiply or restoring division.
// For divide acc_hi/acc_lo hold rem/quo; for multiply the 64-bit accumulator.
module md_iter_step #(
  parameter int XLEN = 32
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] acc_hi,
  input  logic [XLEN-1:0] acc_lo,
  input  logic [XLEN-1:0] operand,
  output logic [XLEN-1:0] next_hi,
  output logic [XLEN-1:0] next_lo
);

  logic [XLEN:0]   sum;
  logic [XLEN:0]   rem_sh;
  logic [XLEN-1:0] diff;
  logic            rem_ge;

  // The shifted remainder needs one extra bit; once the trial subtract
  // succeeds the difference is below the divisor, so XLEN bits suffice.
  always_comb begin
    sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);
    rem_sh  = {acc_hi, acc_lo[XLEN-1]};
    rem_ge  = (rem_sh >= {1'b0, operand});
    diff    = rem_sh[XLEN-1:0] - operand;
    next_hi = sum[XLEN:1];
    next_lo = {sum[0], acc_lo[XLEN-1:1]};
    if (is_div) begin
      if (rem_ge) begin
        next_hi = diff;
        next_lo = {acc_lo[XLEN-2:0], 1'b1};
      end else begin
        next_hi = rem_sh[XLEN-1:0];
        next_lo = {acc_lo[XLEN-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/hilo_md_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning the HI/LO registers;
// stalls the main control FSM while an operation is in flight.
module hilo_md_sequencer
  import hilo_md_sequencer_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [1:0]      md_op_i,
  input  logic [XLEN-1:0] src0_i,
  input  logic [XLEN-1:0] src1_i,
  input  logic            hi_we_i,
  input  logic            lo_we_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic            rd_req_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            stall_o,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o,
  output logic            div0_o
);

  md_state_e        state_q, state_d;
  md_op_e           op_q;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0]  src0_q, src1_q;
  logic [XLEN-1:0]  operand_q;
  logic [XLEN-1:0]  acc_hi_q, acc_lo_q;
  logic             res_neg_q, dvd_neg_q;
  logic             div0_q;
  logic [XLEN-1:0]  hi_q, lo_q;

  logic [XLEN-1:0]   step_hi, step_lo;
  logic [XLEN-1:0]   mag0, mag1;
  logic [XLEN-1:0]   fix_hi, fix_lo;
  logic [2*XLEN-1:0] prod;
  logic              src1_zero;

  md_iter_step #(.XLEN(XLEN)) u_step (
    .is_div  (md_is_div(op_q)),
    .acc_hi  (acc_hi_q),
    .acc_lo  (acc_lo_q),
    .operand (operand_q),
    .next_hi (step_hi),
    .next_lo (step_lo)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  assign src1_zero = (src1_q == '0);

  always_comb begin
    state_d = state_q;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    case (state_q)
      ST_IDLE: if (start_i) state_d = ST_PREP;
      ST_PREP: begin
        busy_o  = 1'b1;
        state_d = (md_is_div(op_q) && src1_zero) ? ST_FIX : ST_CALC;
      end
      ST_CALC: begin
        busy_o = 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = ST_FIX;
      end
      ST_FIX: begin
        busy_o  = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        done_o  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign stall_o = busy_o & (start_i | rd_req_i | hi_we_i | lo_we_i);

  assign mag0 = (md_is_signed(op_q) && src0_q[XLEN-1]) ? -src0_q : src0_q;
  assign mag1 = (md_is_signed(op_q) && src1_q[XLEN-1]) ? -src1_q : src1_q;

  // Multiply iterates over the multiplier in acc_lo; divide shifts the
  // dividend out of acc_lo into the remainder.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_q      <= MD_MULT;
      cnt_q     <= '0;
      src0_q    <= '0;
      src1_q    <= '0;
      operand_q <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      res_neg_q <= 1'b0;
      dvd_neg_q <= 1'b0;
      div0_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (start_i) begin
          op_q   <= md_op_e'(md_op_i);
          src0_q <= src0_i;
          src1_q <= src1_i;
          div0_q <= 1'b0;
        end
        ST_PREP: begin
          cnt_q     <= CNT_W'(XLEN);
          acc_hi_q  <= '0;
          acc_lo_q  <= md_is_div(op_q) ? mag0 : mag1;
          operand_q <= md_is_div(op_q) ? mag1 : mag0;
          res_neg_q <= md_is_signed(op_q) & (src0_q[XLEN-1] ^ src1_q[XLEN-1]);
          dvd_neg_q <= md_is_signed(op_q) & src0_q[XLEN-1];
          if (md_is_div(op_q) && src1_zero) div0_q <= 1'b1;
        end
        ST_CALC: begin
          acc_hi_q <= step_hi;
          acc_lo_q <= step_lo;
          cnt_q    <= cnt_q - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign prod = {acc_hi_q, acc_lo_q};

  always_comb begin
    fix_hi = acc_hi_q;
    fix_lo = acc_lo_q;
    if (md_is_div(op_q)) begin
      if (div0_q) begin
        fix_hi = src0_q;
        fix_lo = '1;
      end else begin
        fix_lo = res_neg_q ? -acc_lo_q : acc_lo_q;
        fix_hi = dvd_neg_q ? -acc_hi_q : acc_hi_q;
      end
    end else if (res_neg_q) begin
      {fix_hi, fix_lo} = -prod;
    end
  end

  // MTHI/MTLO only land while no operation is in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (state_q == ST_FIX) begin
      hi_q <= fix_hi;
      lo_q <= fix_lo;
    end else if (!busy_o) begin
      if (hi_we_i) hi_q <= wdata_i;
      if (lo_we_i) lo_q <= wdata_i;
    end
  end

  assign hi_o   = hi_q;
  assign lo_o   = lo_q;
  assign div0_o = div0_q;

endmodule

// File: doc/hilo_md_sequencer.md
Name: hilo_md_sequencer

Overview:
- Multi-cycle multiply/divide controller for the multicycle MIPS core.
- Takes MULT/MULTU/DIV/DIVU issued by the main control FSM and runs them iteratively: shift-add for multiply, restoring division for divide.
- Owns the architectural HI/LO registers and services MFHI/MFLO/MTHI/MTLO.
- Stalls the control FSM while an operation is in flight, so the single-cycle ALU never carries the 64-bit mul/div path.

Parameters:
- XLEN, 32, operand width (HI/LO width).
- CNT_W, 6, width of the iteration counter (must hold XLEN).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous active-high reset.
- start_i  in  1  issue request; sampled in IDLE only.
- md_op_i  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- src0_i  in  XLEN  rs (multiplicand / dividend).
- src1_i  in  XLEN  rt (multiplier / divisor).
- hi_we_i  in  1  MTHI write strobe.
- lo_we_i  in  1  MTLO write strobe.
- wdata_i  in  XLEN  MTHI/MTLO data.
- rd_req_i  in  1  MFHI/MFLO read pending.
- busy_o  out  1  operation in flight (PREP/CALC/FIX).
- done_o  out  1  one-cycle pulse when HI/LO update is visible.
- stall_o  out  1  busy_o & (start_i | rd_req_i | hi_we_i | lo_we_i).
- hi_o  out  XLEN  HI register (remainder for divide).
- lo_o  out  XLEN  LO register (quotient for divide).
- div0_o  out  1  sticky flag: last divide had divisor 0; cleared on next accepted start.

Behaviour:
- Clock and reset: one clock, clk_i; reset rst_i is synchronous and active-high.
- Reset values: state=IDLE; busy_o=0, done_o=0, div0_o=0; hi_o=0, lo_o=0; counter=0.
- Reset asserted mid-operation aborts it. HI/LO go to 0 and no done_o pulse is produced.
- FSM states: IDLE, PREP, CALC, FIX, DONE.
  - IDLE -> PREP on start_i. Latch op and operands; clear div0_o.
  - PREP, 1 cycle:
    - Signed ops: take magnitudes of both operands and record result sign (s0^s1) and dividend sign.
    - Load counter = XLEN.
    - Divide with src1=0: set div0_o and go directly to FIX.
  - CALC, exactly XLEN cycles, one iteration per cycle.
    - Multiply: if multiplier LSB is set, add multiplicand to the upper half of a 64-bit accumulator; then shift the {carry, acc} pair right by 1.
    - Divide: shift {rem, quo} left by 1, trial-subtract divisor from rem; if non-negative keep the difference and set quo[0].
    - Counter decrements each cycle; CALC -> FIX when counter reaches 1.
  - FIX, 1 cycle:
    - Signed ops: negate the 64-bit product if the result sign is set; negate the quotient if (s0^s1); negate the remainder if the dividend was negative.
    - Write HI/LO at the end of this cycle.
  - DONE, 1 cycle: done_o=1, then return to IDLE.
- Latency: start_i accepted at edge N; busy_o high for cycles N+1..N+34; done_o high and new HI/LO visible in cycle N+35. The next start is accepted in DONE+1 at the earliest.
- Divide by zero: HI=dividend (unmodified src0), LO=0xFFFFFFFF. div0_o=1 until the next start.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0 (wraps, no trap).
- The counter never wraps; CALC runs exactly XLEN iterations regardless of operand values (no early exit).
- start_i, hi_we_i, lo_we_i while busy: ignored, and stall_o is raised. The control FSM holds the request until stall_o drops.
- MTHI/MTLO in IDLE: register written at the clock edge. hi_we_i and lo_we_i may be asserted in the same cycle.
- start_i together with hi_we_i/lo_we_i in IDLE: the MT write occurs and the operation starts; the operation's result overwrites HI/LO later.
- rd_req_i in IDLE or DONE: no stall; hi_o/lo_o are directly readable.

Decomposition:
- Shared constants, added to the existing instruction-definition header: the MD_OP encodings (MULT/MULTU/DIV/DIVU) and the FSM state encodings.
- One sub-module: md_iter_step. Purely combinational single iteration that takes op class plus acc/rem/quo/operand and returns the next values. The sequencer holds all registers and the FSM.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; done_o exactly 35 cycles after start.
- MULT 0xFFFFFFFD (-3) x 5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- DIV 0xFFFFFFF9 (-7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100/7 -> LO=14, HI=2.
- DIVU 0x1234 / 0 -> HI=0x1234, LO=0xFFFFFFFF, div0_o=1; next MULTU 2x3 clears div0_o, giving LO=6.
- MULT in flight, then start_i, mtlo, and rd_req_i pulsed at cycle N+10 -> stall_o=1, HI/LO unaffected until done; MTLO 0xAA in IDLE -> lo_o=0xAA next cycle.
- rst_i asserted at cycle N+20 of a DIV -> next cycle busy_o=0, HI=LO=0, no done_o; a fresh DIVU 9/3 completes normally with LO=3, HI=0.
